// File: rtl/tx_queue_pkg.sv
// Shared encodings and buffer-entry layout for the 10G transmit queue.
package tx_queue_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned STRB_W  = 8;
  localparam int unsigned ENTRY_W = DATA_W + STRB_W + 1;

  // Buffer entry layout: {tlast, tstrb, tdata}
  localparam int unsigned ENTRY_DATA_LSB = 0;
  localparam int unsigned ENTRY_STRB_LSB = DATA_W;
  localparam int unsigned ENTRY_LAST_BIT = DATA_W + STRB_W;

  localparam logic [STRB_W-1:0] STRB_FULL = 8'hFF;
  localparam logic [STRB_W-1:0] STRB_NONE = 8'h00;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_SEND  = 3'd2,
    TX_DROP  = 3'd3,
    TX_GAP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/tx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with fill level.
module tx_sync_fifo #(
  parameter int unsigned WIDTH     = 73,
  parameter int unsigned ADDR_BITS = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_wr_en,
  input  logic [WIDTH-1:0]     i_wr_data,
  input  logic                 i_rd_en,
  output logic [WIDTH-1:0]     o_rd_data_c,
  output logic                 o_full_c,
  output logic                 o_empty_c,
  output logic [ADDR_BITS:0]   o_level
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned LW    = ADDR_BITS + 1;

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 w_wr;
  logic                 w_rd;

  assign o_full_c    = (r_level == LW'(DEPTH));
  assign o_empty_c   = (r_level == '0);
  assign o_level     = r_level;
  assign o_rd_data_c = r_mem[r_rd_ptr];

  // Full never accepts a write, empty is never popped.
  assign w_wr = i_wr_en & ~o_full_c;
  assign w_rd = i_rd_en & ~o_empty_c;

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointers and fill level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_BITS'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_BITS'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/tx_queue.sv
// Store-and-forward AXI4-Stream to 10G MAC client TX converter with cut-through fallback.
module tx_queue
  import tx_queue_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned FIFO_ADDR_BITS = 9,
  parameter bit          CUT_THROUGH_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [AXI_DATA_WIDTH-1:0] tdata,
  input  logic [7:0]                tstrb,
  input  logic                      tvalid,
  input  logic                      tlast,
  output logic                      tready,
  output logic [63:0]               tx_data,
  output logic [7:0]                tx_data_valid,
  output logic                      tx_start,
  input  logic                      tx_ack,
  output logic                      tx_underrun,
  output logic                      pkt_start
);

  localparam int unsigned DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int unsigned LW    = FIFO_ADDR_BITS + 1;
  localparam logic [LW-1:0] TREADY_LIMIT = LW'(DEPTH - 2);
  localparam logic [LW-1:0] CNT_MAX      = {LW{1'b1}};

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic                 r_tready;
  logic [63:0]          r_tx_data;
  logic [7:0]           r_tx_data_valid;
  logic                 r_tx_start;
  logic                 r_tx_underrun;
  logic                 r_pkt_start;
  logic                 r_w0_last;
  logic [LW-1:0]        r_pkt_count;
  logic                 r_ct_owe;

  logic                 w_wr;
  logic                 w_pop;
  logic [ENTRY_W-1:0]   w_wr_entry;
  logic [ENTRY_W-1:0]   w_head;
  logic                 w_full_c;
  logic                 w_empty_c;
  logic [LW-1:0]        w_level;
  logic [LW-1:0]        w_level_nxt;
  logic                 w_head_last;
  logic [7:0]           w_head_strb;
  logic [63:0]          w_head_data;
  logic                 w_ct_go;
  logic                 w_leave_idle;
  logic                 w_inc;
  logic                 w_inc_eff;
  logic                 w_emit;
  logic [63:0]          w_data_nxt;
  logic [7:0]           w_dv_nxt;
  logic                 w_start_nxt;
  logic                 w_underrun_nxt;
  logic                 w_pkt_start_nxt;
  logic                 w_w0_last_nxt;

  assign tready        = r_tready;
  assign tx_data       = r_tx_data;
  assign tx_data_valid = r_tx_data_valid;
  assign tx_start      = r_tx_start;
  assign tx_underrun   = r_tx_underrun;
  assign pkt_start     = r_pkt_start;

  assign w_wr       = tvalid & r_tready;
  assign w_wr_entry = {tlast, tstrb, tdata};

  tx_sync_fifo #(
    .WIDTH     (ENTRY_W),
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_wr_en     (w_wr),
    .i_wr_data   (w_wr_entry),
    .i_rd_en     (w_pop),
    .o_rd_data_c (w_head),
    .o_full_c    (w_full_c),
    .o_empty_c   (w_empty_c),
    .o_level     (w_level)
  );

  assign w_head_last = w_head[ENTRY_LAST_BIT];
  assign w_head_strb = w_head[ENTRY_STRB_LSB +: STRB_W];
  assign w_head_data = w_head[ENTRY_DATA_LSB +: DATA_W];

  // tready stalls at depth-2, so the writer can never fill the last two slots;
  // cut-through therefore triggers on that stall level as well as on true full.
  assign w_level_nxt = w_level + LW'(w_wr) - LW'(w_pop);
  assign w_ct_go     = CUT_THROUGH_EN && (w_full_c || (w_level >= TREADY_LIMIT));

  assign w_leave_idle = (r_state == TX_IDLE) && (w_state_nxt != TX_IDLE);
  assign w_inc        = w_wr & tlast;
  // A cut-through frame leaves idle before its tlast arrives; that tlast must not count again.
  assign w_inc_eff    = w_inc & ~r_ct_owe;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_emit          = 1'b0;
    w_data_nxt      = '0;
    w_dv_nxt        = STRB_NONE;
    w_start_nxt     = 1'b0;
    w_underrun_nxt  = 1'b0;
    w_pkt_start_nxt = 1'b0;
    w_w0_last_nxt   = r_w0_last;

    case (r_state)
      TX_IDLE: begin
        if ((r_pkt_count != '0) || w_ct_go) begin
          w_pop           = 1'b1;
          w_data_nxt      = w_head_data;
          w_dv_nxt        = w_head_strb;
          w_start_nxt     = 1'b1;
          w_pkt_start_nxt = 1'b1;
          w_w0_last_nxt   = w_head_last;
          w_state_nxt     = TX_START;
        end
      end
      TX_START: begin
        w_start_nxt = 1'b1;
        w_data_nxt  = r_tx_data;
        w_dv_nxt    = r_tx_data_valid;
        if (tx_ack) begin
          if (r_w0_last) begin
            w_start_nxt = 1'b0;
            w_data_nxt  = '0;
            w_dv_nxt    = STRB_NONE;
            w_state_nxt = TX_GAP;
          end else begin
            w_emit = 1'b1;
          end
        end
      end
      TX_SEND: w_emit = 1'b1;
      TX_DROP: begin
        if (!w_empty_c) begin
          w_pop = 1'b1;
          if (w_head_last) w_state_nxt = TX_GAP;
        end
      end
      TX_GAP:  w_state_nxt = TX_IDLE;
      default: w_state_nxt = TX_IDLE;
    endcase

    if (w_emit) begin
      w_start_nxt = 1'b0;
      w_data_nxt  = '0;
      w_dv_nxt    = STRB_NONE;
      if (w_empty_c) begin
        w_underrun_nxt = 1'b1;
        w_state_nxt    = TX_DROP;
      end else begin
        w_pop = 1'b1;
        if (w_head_last) begin
          w_state_nxt = TX_GAP;
          if (w_head_strb == STRB_NONE) begin
            w_underrun_nxt = 1'b1;
          end else begin
            w_data_nxt = w_head_data;
            w_dv_nxt   = w_head_strb;
          end
        end else begin
          w_data_nxt  = w_head_data;
          w_dv_nxt    = w_head_strb;
          w_state_nxt = TX_SEND;
        end
      end
    end
  end

  // FSM state and registered MAC-side outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= TX_IDLE;
      r_tx_data       <= '0;
      r_tx_data_valid <= STRB_NONE;
      r_tx_start      <= 1'b0;
      r_tx_underrun   <= 1'b0;
      r_pkt_start     <= 1'b0;
      r_w0_last       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_tx_data       <= w_data_nxt;
      r_tx_data_valid <= w_dv_nxt;
      r_tx_start      <= w_start_nxt;
      r_tx_underrun   <= w_underrun_nxt;
      r_pkt_start     <= w_pkt_start_nxt;
      r_w0_last       <= w_w0_last_nxt;
    end
  end

  // AXI ready reflects the level after this cycle's read/write.
  always_ff @(posedge clk) begin
    if (!reset_n) r_tready <= 1'b0;
    else          r_tready <= (w_level_nxt < TREADY_LIMIT);
  end

  // Count of complete packets held in the buffer, saturating at both ends.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pkt_count <= '0;
      r_ct_owe    <= 1'b0;
    end else begin
      case ({w_inc_eff, w_leave_idle})
        2'b10:   if (r_pkt_count != CNT_MAX) r_pkt_count <= r_pkt_count + LW'(1);
        2'b01:   if (r_pkt_count != '0)      r_pkt_count <= r_pkt_count - LW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
      if (w_inc && r_ct_owe)
        r_ct_owe <= 1'b0;
      else if (w_leave_idle && !w_inc_eff && (r_pkt_count == '0))
        r_ct_owe <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_queue.sv
// Scoreboard bench for tx_queue: AXI driver, MAC ack model and TX-side monitor.
module tb_tx_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] tdata;
  logic [7:0]  tstrb;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [63:0] tx_data;
  logic [7:0]  tx_data_valid;
  logic        tx_start;
  logic        tx_ack = 1'b0;
  logic        tx_underrun;
  logic        pkt_start;

  always #5 clk = ~clk;

  tx_queue #(
    .AXI_DATA_WIDTH (64),
    .FIFO_ADDR_BITS (9),
    .CUT_THROUGH_EN (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tdata         (tdata),
    .tstrb         (tstrb),
    .tvalid        (tvalid),
    .tlast         (tlast),
    .tready        (tready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_start      (tx_start),
    .tx_ack        (tx_ack),
    .tx_underrun   (tx_underrun),
    .pkt_start     (pkt_start)
  );

  typedef struct packed {
    logic        last;
    logic [7:0]  s;
    logic [63:0] d;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // MAC model: ack after a fixed delay, one chosen frame gets a long delay.
  int long_frame_idx = -1;
  int mac_frames     = 0;
  int ack_cnt        = 0;
  int cur_dly        = 3;
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      if (ack_cnt == 0) begin
        cur_dly = (mac_frames == long_frame_idx) ? 700 : 3;
        mac_frames++;
      end
      tx_ack = (ack_cnt >= cur_dly);
      ack_cnt++;
    end else begin
      ack_cnt = 0;
      tx_ack  = 1'b0;
    end
  end

  // Monitor
  bit mon_en   = 1'b0;
  bit hs_chk   = 1'b0;
  bit b2b_chk  = 1'b0;
  bit prev_start, prev_pstart, gap_pending;
  int frames    = 0;
  int underruns = 0;
  int start_len, exp_start_len;
  int last_cyc  = -1;
  int tlast_cyc = 0;

  task automatic pop_compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq({tag, "_unexpected"}, 72'(tx_data_valid), 72'(0));
    end else begin
      e = sb.pop_front();
      check_eq(tag, {tx_data_valid, tx_data}, {e.s, e.d});
      if (e.last) begin
        last_cyc    = cyc;
        gap_pending = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!b2b_chk) last_cyc = -1;
    if (!mon_en) begin
      sb.delete();
      gap_pending = 1'b0;
      prev_start  = 1'b0;
      prev_pstart = 1'b0;
    end else begin
      if (gap_pending) begin
        check_eq("gap_bubble", 72'({tx_start, tx_data_valid}), 72'(0));
        gap_pending = 1'b0;
      end
      if (pkt_start) begin
        check_eq("pkt_start_pulse", 72'({prev_pstart, prev_start, tx_start}), 72'(3'b001));
        if (hs_chk) check_eq("start_latency", 72'(cyc - tlast_cyc), 72'(2));
        if (b2b_chk && last_cyc >= 0) check_eq("b2b_spacing", 72'(cyc - last_cyc), 72'(2));
        exp_start_len = (frames == long_frame_idx) ? 701 : 4;
        start_len     = 1;
        frames++;
        pop_compare("word0");
      end else if (tx_start) begin
        if (!prev_start) check_eq("pkt_start_on_rise", 72'(pkt_start), 72'(1));
        start_len++;
      end
      if (prev_start && !tx_start) check_eq("start_len", 72'(start_len), 72'(exp_start_len));
      if (!tx_start && tx_data_valid != 8'h00) pop_compare("word");
      if (tx_underrun) begin
        underruns++;
        check_eq("underrun_dv", 72'(tx_data_valid), 72'(0));
      end
      prev_start  = tx_start;
      prev_pstart = pkt_start;
    end
  end

  // Driver
  int pkt_id = 0;
  int n_acc  = 0;
  bit push_en = 1'b1;
  bit bp_arm  = 1'b0;
  bit bp_seen = 1'b0;
  int bp_acc  = 0;

  task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    exp_t e;
    int waited = 0;
    tdata  = d;
    tstrb  = s;
    tlast  = l;
    tvalid = 1'b1;
    while (tready !== 1'b1) begin
      if (bp_arm && !bp_seen) begin
        bp_seen = 1'b1;
        bp_acc  = n_acc;
      end
      @(negedge clk);
      waited++;
      if (waited > 5000) begin
        check_eq("tready_wait", 72'(tready), 72'(1));
        tvalid = 1'b0;
        return;
      end
    end
    e.last = l;
    e.s    = s;
    e.d    = d;
    if (push_en) sb.push_back(e);
    if (l) tlast_cyc = cyc;
    n_acc++;
    @(negedge clk);
  endtask

  task automatic send_pkt(input int nbytes, input bit drop_valid);
    int beats = (nbytes + 7) / 8;
    int rem   = nbytes - 8 * (beats - 1);
    logic [8:0] m;
    m = (9'd1 << rem) - 9'd1;
    for (int i = 0; i < beats; i++) begin
      send_beat({8'(pkt_id), 24'(i), 32'($urandom)},
                (i == beats - 1) ? m[7:0] : 8'hFF, (i == beats - 1));
    end
    pkt_id++;
    if (drop_valid) tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int n_exp, input int budget);
    int k = 0;
    while ((frames < n_exp || sb.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check_eq("frames", 72'(frames), 72'(n_exp));
    check_eq("sb_left", 72'(sb.size()), 72'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    tvalid  = 1'b0;
    tdata   = '0;
    tstrb   = '0;
    tlast   = 1'b0;
    @(negedge clk);
    check_eq("rst_data", 72'(tx_data), 72'(0));
    check_eq("rst_ctl", 72'({tready, tx_start, tx_underrun, pkt_start, tx_data_valid}), 72'(0));
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // Single 64 B packet, then odd 61 B packet
    hs_chk = 1'b1;
    send_pkt(64, 1'b1);
    wait_frames(1, 200);
    send_pkt(61, 1'b1);
    wait_frames(2, 200);
    hs_chk = 1'b0;
    check_eq("no_underrun_basic", 72'(underruns), 72'(0));

    // Back-to-back 3 x 60 B with tvalid held high
    b2b_chk = 1'b1;
    send_pkt(60, 1'b0);
    send_pkt(60, 1'b0);
    send_pkt(60, 1'b1);
    wait_frames(5, 300);
    b2b_chk = 1'b0;
    idle(50);
    check_eq("no_phantom_b2b", 72'(frames), 72'(5));

    // Backpressure: first frame's ack held for 700 cycles
    long_frame_idx = 5;
    n_acc   = 0;
    bp_seen = 1'b0;
    bp_arm  = 1'b1;
    for (int p = 0; p < 9; p++) send_pkt(480, (p == 8));
    wait_frames(14, 5000);
    bp_arm = 1'b0;
    check_eq("bp_seen", 72'(bp_seen), 72'(1));
    check_eq("bp_accepted_at_stall", 72'(bp_acc), 72'(511));

    // Cut-through with an input gap long enough to drain the buffer
    for (int i = 0; i < 520; i++) send_beat({8'(pkt_id), 24'(i), 32'($urandom)}, 8'hFF, 1'b0);
    idle(700);
    push_en = 1'b0;
    for (int i = 520; i < 625; i++) send_beat({8'(pkt_id), 24'(i), 32'($urandom)}, 8'hFF, (i == 624));
    push_en = 1'b1;
    pkt_id++;
    tvalid = 1'b0;
    check_eq("underrun_once", 72'(underruns), 72'(1));
    send_pkt(64, 1'b1);
    wait_frames(16, 3000);
    idle(50);
    check_eq("no_phantom_ct", 72'(frames), 72'(16));
    check_eq("underrun_total", 72'(underruns), 72'(1));

    // Reset during TX_SEND
    send_pkt(320, 1'b1);
    begin
      int k = 0;
      while (!(frames == 17 && tx_start === 1'b0 && tx_data_valid != 8'h00) && k < 500) begin
        @(negedge clk);
        k++;
      end
    end
    repeat (5) @(negedge clk);
    check_eq("mid_frame_sending", 72'(tx_data_valid), 72'(8'hFF));
    mon_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("rstmid_data", 72'(tx_data), 72'(0));
    check_eq("rstmid_ctl", 72'({tready, tx_start, tx_underrun, pkt_start, tx_data_valid}), 72'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    send_pkt(64, 1'b1);
    wait_frames(18, 300);
    check_eq("underrun_after_rst", 72'(underruns), 72'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
